// File: rtl/regfile_writeback_if.sv
// Writeback bundle: ALU/load request handshakes, issue tracking, register-file write port, scoreboard view.
interface regfile_writeback_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] busy;
  logic        sb_overflow;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    input  alu_ready, mem_ready,
    input  WE3, A3, WD3, busy, sb_overflow
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    output alu_ready, mem_ready,
    output WE3, A3, WD3, busy, sb_overflow
  );
endinterface

// File: rtl/regfile_writeback.sv
// Round-robin ALU/load writeback arbiter feeding a DEPTH-entry queue that drains one write per cycle,
// plus a 2-bit-per-register pending-write scoreboard. Define WB_BYPASS_EN for the empty-queue bypass.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_writeback_if.slave wb
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t   q_mem [DEPTH];
  wb_entry_t   acc_ent;
  wb_entry_t   head;
  wb_entry_t   last_q;
  wb_entry_t   out_ent;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        rr_mem;
  logic        alu_ready;
  logic        mem_ready;
  logic        alu_acc;
  logic        mem_acc;
  logic        keep;
  logic        push;
  logic        pop;
  logic        we3;

  logic [1:0]  cnt [1:31];
  logic [31:0] inc_req;
  logic [31:0] dec_hit;
  logic [31:0] at_max;
  logic [31:0] busy_v;
  logic        ovf_hit;
  logic        sb_ovf_q;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = q_mem[rd_ptr];

  // Each ready looks only at the other source's valid, never its own.
  always_comb begin
    alu_ready = !rst && !full && (!wb.mem_valid || !rr_mem);
    mem_ready = !rst && !full && (!wb.alu_valid ||  rr_mem);
  end

  assign alu_acc = wb.alu_valid && alu_ready;
  assign mem_acc = wb.mem_valid && mem_ready;

  always_comb begin
    acc_ent.rd   = wb.alu_rd;
    acc_ent.data = wb.alu_data;
    if (mem_acc) begin
      acc_ent.rd   = wb.mem_rd;
      acc_ent.data = wb.mem_data;
    end
  end

  // Writes to x0 finish their handshake here and go no further.
  assign keep = (alu_acc || mem_acc) && (acc_ent.rd != 5'd0);
  assign pop  = !empty;

`ifdef WB_BYPASS_EN
  logic bypass;
  assign bypass = empty && keep;
  assign push   = keep && !bypass;

  always_comb begin
    we3     = 1'b0;
    out_ent = last_q;
    if (pop) begin
      we3     = 1'b1;
      out_ent = head;
    end else if (bypass) begin
      we3     = 1'b1;
      out_ent = acc_ent;
    end
  end
`else
  assign push = keep;

  always_comb begin
    we3     = 1'b0;
    out_ent = last_q;
    if (pop) begin
      we3     = 1'b1;
      out_ent = head;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_mem <= 1'b1;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (alu_acc)      rr_mem <= 1'b1;
      else if (mem_acc) rr_mem <= 1'b0;
      // A3/WD3 hold the most recent write once the queue runs dry.
      if (we3) last_q <= out_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= acc_ent;
  end

  always_comb begin
    inc_req = '0;
    dec_hit = '0;
    at_max  = '0;
    busy_v  = '0;
    for (int r = 1; r < 32; r++) begin
      inc_req[r] = wb.issue_valid && (wb.issue_rd == 5'(r));
      dec_hit[r] = we3 && (out_ent.rd == 5'(r));
      at_max[r]  = (cnt[r] == 2'd3);
      busy_v[r]  = (cnt[r] != 2'd0);
    end
  end

  // A same-cycle commit frees the slot, so an issue to a saturated register is not an overflow then.
  assign ovf_hit = |(inc_req & ~dec_hit & at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) cnt[r] <= 2'd0;
      sb_ovf_q <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_req[r] && !dec_hit[r] && !at_max[r])
          cnt[r] <= cnt[r] + 2'd1;
        else if (dec_hit[r] && !inc_req[r] && (cnt[r] != 2'd0))
          cnt[r] <= cnt[r] - 2'd1;
      end
      if (ovf_hit) sb_ovf_q <= 1'b1;
    end
  end

  assign wb.alu_ready   = alu_ready;
  assign wb.mem_ready   = mem_ready;
  assign wb.WE3         = we3;
  assign wb.A3          = out_ent.rd;
  assign wb.WD3         = out_ent.data;
  assign wb.busy        = busy_v;
  assign wb.sb_overflow = sb_ovf_q;

endmodule
